// File: rtl/flash_read_arbiter.sv
// ============================================================================
// Module  : flash_read_arbiter
// Purpose : Two-port arbiter sequencing reads against a fixed flash latency.
//           Define FLASH_ARB_RR_EN for round-robin ties (else port 0 wins).
// Revision: 1.0
// ============================================================================
`default_nettype none

module flash_read_arbiter #(
  parameter int LATENCY = 11,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              flash_ready,
  output logic [ADDR_W-1:0] flash_address,
  input  logic [DATA_W-1:0] flashData_out
);

  localparam int                 c_CNT_W = $clog2(LATENCY);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(LATENCY - 2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_owner;
  logic                r_gnt0;
  logic                r_gnt1;
  logic                r_rvalid0;
  logic                r_rvalid1;
  logic                r_busy;
  logic                r_flash_ready;
  logic [ADDR_W-1:0]   r_flash_address;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_pick1;
  logic                w_any_req;

  assign w_any_req = req0 | req1;

`ifdef FLASH_ARB_RR_EN
  logic r_last_gnt;

  // On a tie, port 1 wins only when port 0 was granted last.
  assign w_pick1 = req1 & (~req0 | ~r_last_gnt);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_last_gnt <= 1'b1;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_last_gnt <= w_pick1;
    end
  end
`else
  assign w_pick1 = req1 & ~req0;
`endif

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_owner         <= 1'b0;
      r_gnt0          <= 1'b0;
      r_gnt1          <= 1'b0;
      r_rvalid0       <= 1'b0;
      r_rvalid1       <= 1'b0;
      r_busy          <= 1'b0;
      r_flash_ready   <= 1'b0;
      r_flash_address <= '0;
      r_rdata         <= '0;
    end else begin
      r_gnt0        <= 1'b0;
      r_gnt1        <= 1'b0;
      r_flash_ready <= 1'b0;
      r_rvalid0     <= 1'b0;
      r_rvalid1     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner         <= w_pick1;
            r_flash_address <= w_pick1 ? addr1 : addr0;
            r_gnt0          <= ~w_pick1;
            r_gnt1          <= w_pick1;
            r_flash_ready   <= 1'b1;
            r_busy          <= 1'b1;
            r_state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == c_LAST) begin
            r_state <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        S_CAPTURE: begin
          r_rdata   <= flashData_out;
          r_rvalid0 <= ~r_owner;
          r_rvalid1 <= r_owner;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt0          = r_gnt0;
  assign gnt1          = r_gnt1;
  assign rvalid0       = r_rvalid0;
  assign rvalid1       = r_rvalid1;
  assign rdata         = r_rdata;
  assign busy          = r_busy;
  assign flash_ready   = r_flash_ready;
  assign flash_address = r_flash_address;

endmodule

`default_nettype wire

// File: tb/tb_flash_read_arbiter.sv
// ============================================================================
// Module  : tb_flash_read_arbiter
// Purpose : Directed self-checking bench for flash_read_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_flash_read_arbiter;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        req0, req1;
  logic [15:0] addr0, addr1;
  logic        gnt0, gnt1, rvalid0, rvalid1, busy, flash_ready;
  logic [15:0] rdata, flash_address, flashData_out;

  logic        b_req0, b_req1;
  logic [15:0] b_addr0, b_addr1;
  logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_busy, b_flash_ready;
  logic [15:0] b_rdata, b_flash_address, b_flashData_out;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] flash_model(input logic [15:0] a);
    case (a)
      16'h0040: flash_model = 16'hA5C3;
      16'h0010: flash_model = 16'h1111;
      16'h0020: flash_model = 16'h2222;
      default:  flash_model = ~a;
    endcase
  endfunction

  assign flashData_out   = flash_model(flash_address);
  assign b_flashData_out = flash_model(b_flash_address);

  flash_read_arbiter #(.LATENCY(11), .ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .n_rst(n_rst), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata), .busy(busy),
    .flash_ready(flash_ready), .flash_address(flash_address),
    .flashData_out(flashData_out)
  );

  flash_read_arbiter #(.LATENCY(2), .ADDR_W(16), .DATA_W(16)) dut_min (
    .clk(clk), .n_rst(n_rst), .req0(b_req0), .req1(b_req1),
    .addr0(b_addr0), .addr1(b_addr1), .gnt0(b_gnt0), .gnt1(b_gnt1),
    .rvalid0(b_rvalid0), .rvalid1(b_rvalid1), .rdata(b_rdata), .busy(b_busy),
    .flash_ready(b_flash_ready), .flash_address(b_flash_address),
    .flashData_out(b_flashData_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic        seen;
    logic [1:0]  tie_exp [4];
    n_rst = 1'b0;
    req0 = 0; req1 = 0; addr0 = 0; addr1 = 0;
    b_req0 = 0; b_req1 = 0; b_addr0 = 0; b_addr1 = 0;
`ifdef FLASH_ARB_RR_EN
    tie_exp = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
    tie_exp = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif

    // Reset state
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {gnt0, gnt1}, 0);
    chk("rst_rvalid", {rvalid0, rvalid1}, 0);
    chk("rst_fready", flash_ready, 0);
    chk("rst_addr", flash_address, 0);
    chk("rst_rdata", rdata, 0);
    n_rst = 1'b1;
    tick();

    // Single read: cycle 0 is IDLE with req0 high
    addr0 = 16'h0040; req0 = 1;
    tick();
    chk("single_gnt0", gnt0, 1);
    chk("single_gnt1", gnt1, 0);
    chk("single_fready", flash_ready, 1);
    chk("single_addr", flash_address, 16'h0040);
    chk("single_busy", busy, 1);
    req0 = 0;
    seen = 0;
    for (int c = 2; c <= 12; c++) begin
      tick();
      if (rvalid0 || rvalid1 || flash_ready) seen = 1;
    end
    chk("single_quiet_wait", seen, 0);
    tick();
    chk("single_rvalid0", rvalid0, 1);
    chk("single_rvalid1", rvalid1, 0);
    chk("single_rdata", rdata, 16'hA5C3);
    tick();
    chk("single_idle_busy", busy, 0);
    chk("single_idle_rvalid0", rvalid0, 0);

    // Late arrival: req1 rises at cycle 5 of a port-0 read
    addr0 = 16'h0010; req0 = 1;
    tick();
    chk("late_gnt0", gnt0, 1);
    req0 = 0;
    for (int c = 2; c <= 5; c++) tick();
    addr1 = 16'h0020; req1 = 1;
    for (int c = 6; c <= 13; c++) tick();
    chk("late_rvalid0", rvalid0, 1);
    chk("late_rdata0", rdata, 16'h1111);
    tick();
    chk("late_idle_gnt1", gnt1, 0);
    chk("late_idle_busy", busy, 0);
    tick();
    chk("late_gnt1", gnt1, 1);
    chk("late_addr1", flash_address, 16'h0020);
    req1 = 0;
    for (int c = 16; c <= 27; c++) tick();
    chk("late_rvalid1", rvalid1, 1);
    chk("late_rdata1", rdata, 16'h2222);
    tick();

    // Tie from a fresh reset
    n_rst = 0; tick(); n_rst = 1; tick();
    addr0 = 16'h0010; addr1 = 16'h0020; req0 = 1; req1 = 1;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("tie_gnt", {gnt1, gnt0}, (tie_exp[k] == 2'd1) ? 2'b10 : 2'b01);
      chk("tie_addr", flash_address, (tie_exp[k] == 2'd1) ? 16'h0020 : 16'h0010);
      if (k == 3) begin
        req0 = 0; req1 = 0;
      end
      for (int c = 0; c < 12; c++) tick();
      chk("tie_rvalid", {rvalid1, rvalid0}, (tie_exp[k] == 2'd1) ? 2'b10 : 2'b01);
      chk("tie_rdata", rdata, (tie_exp[k] == 2'd1) ? 16'h2222 : 16'h1111);
      tick(); tick();
    end

    // Reset mid-WAIT
    addr0 = 16'h0040; req0 = 1;
    tick();
    chk("rstw_gnt0", gnt0, 1);
    req0 = 0;
    for (int c = 2; c <= 6; c++) tick();
    chk("rstw_busy_before", busy, 1);
    n_rst = 0;
    tick();
    n_rst = 1;
    chk("rstw_busy", busy, 0);
    chk("rstw_addr", flash_address, 0);
    chk("rstw_rdata", rdata, 0);
    chk("rstw_pulses", {gnt0, gnt1, rvalid0, rvalid1, flash_ready}, 0);
    seen = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (rvalid0 || rvalid1) seen = 1;
    end
    chk("rstw_no_rvalid", seen, 0);
    addr0 = 16'h0010; req0 = 1;
    tick();
    chk("rstw_new_gnt0", gnt0, 1);
    req0 = 0;
    for (int c = 2; c <= 13; c++) tick();
    chk("rstw_new_rvalid0", rvalid0, 1);
    chk("rstw_new_rdata", rdata, 16'h1111);
    tick();

    // Minimum latency instance
    b_addr0 = 16'h0040; b_req0 = 1;
    tick();
    chk("min_gnt0", b_gnt0, 1);
    b_req0 = 0;
    tick(); tick();
    chk("min_rvalid_c3", b_rvalid0, 0);
    tick();
    chk("min_rvalid_c4", b_rvalid0, 1);
    chk("min_rdata", b_rdata, 16'hA5C3);
    tick();
    chk("min_idle_busy", b_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
